// File: rtl/ap_txn_pkg.sv
// ap_txn_pkg
// Shared types and default sizing for the HLS block-level handshake recorder.
//   - txn_state_e : recorder FSM states
//   - txn_rec_t   : record layout at default widths {incomplete, stall, latency, start_ts}
//   - *_DEF       : default values for the FIFO_DEPTH / TS_W / LAT_W parameters
package ap_txn_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned TS_W_DEF       = 32;
  localparam int unsigned LAT_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BUSY      = 2'd1,
    ST_WAIT_CONT = 2'd2,
    ST_FINISHED  = 2'd3
  } txn_state_e;

  typedef struct packed {
    logic                 incomplete;
    logic [LAT_W_DEF-1:0] stall;
    logic [LAT_W_DEF-1:0] latency;
    logic [TS_W_DEF-1:0]  start_ts;
  } txn_rec_t;

endpackage

// File: rtl/ap_txn_rec_fifo.sv
// ap_txn_rec_fifo
// First-word fall-through record FIFO. The head entry is visible on 'head'
// whenever the FIFO is non-empty. A push while full is only taken when a pop
// happens in the same cycle; otherwise the caller is expected to count a drop.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data
//   pop               : consume head (ignored when empty)
//   full, empty       : occupancy flags
//   head              : current head entry (zero when empty)
module ap_txn_rec_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign do_pop_s  = pop & ~empty_s;
  // A pop in the same cycle frees the slot being written when full.
  assign do_push_s = push & (~full_s | do_pop_s);

  assign full  = full_s;
  assign empty = empty_s;
  assign head  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ap_txn_recorder.sv
// ap_txn_recorder
// Watches the ap_start/ap_ready/ap_done/ap_continue handshake of an HLS block
// and emits one record per transaction: start timestamp, latency (accept to
// done), stall (cycles ap_done waited for ap_continue) and an incomplete flag
// for transactions cut short by 'finish'. Records queue in an FWFT FIFO.
// Ports:
//   ap_clk, ap_rst_n             : clock, asynchronous active-low reset
//   mon_start/ready/done/continue: observed handshake signals
//   finish                       : end of run; closes any open record
//   rec_valid, rec_ready, rec_data : record stream {incomplete, stall, latency, start_ts}
//   drop_cnt, overflow           : saturating drop count, sticky overflow flag
module ap_txn_recorder
  import ap_txn_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned TS_W       = TS_W_DEF,
  parameter int unsigned LAT_W      = LAT_W_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    mon_start,
  input  logic                    mon_ready,
  input  logic                    mon_done,
  input  logic                    mon_continue,
  input  logic                    finish,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [TS_W+2*LAT_W:0]   rec_data,
  output logic [LAT_W-1:0]        drop_cnt,
  output logic                    overflow
);

  localparam int unsigned REC_W = TS_W + 2 * LAT_W + 1;

  // Saturating increment shared by latency, stall and drop counters.
  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (v == {LAT_W{1'b1}}) ? v : v + LAT_W'(1);
  endfunction

  txn_state_e       state_r, state_nxt;
  logic [TS_W-1:0]  cycle_cnt_r;
  logic [TS_W-1:0]  ts_r, ts_nxt;
  logic [LAT_W-1:0] lat_r, lat_nxt;
  logic [LAT_W-1:0] stall_r, stall_nxt;
  logic [LAT_W-1:0] lat_inc_s;
  logic [LAT_W-1:0] stall_inc_s;
  logic             accept_s;
  logic             push_s;
  logic [REC_W-1:0] push_rec_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             drop_s;
  logic [LAT_W-1:0] drop_cnt_r;
  logic             overflow_r;

  assign accept_s    = mon_start & mon_ready;
  // lat_r counts completed BUSY cycles; the value for a done in this cycle is one more.
  assign lat_inc_s   = sat_inc(lat_r);
  assign stall_inc_s = sat_inc(stall_r);
  assign pop_s       = rec_ready & ~empty_s;
  assign drop_s      = push_s & full_s & ~pop_s;

  // Free-running timestamp.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cycle_cnt_r <= {TS_W{1'b0}};
    end else begin
      cycle_cnt_r <= cycle_cnt_r + TS_W'(1);
    end
  end

  // FSM state and in-flight record fields.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= ST_IDLE;
      ts_r    <= {TS_W{1'b0}};
      lat_r   <= {LAT_W{1'b0}};
      stall_r <= {LAT_W{1'b0}};
    end else begin
      state_r <= state_nxt;
      ts_r    <= ts_nxt;
      lat_r   <= lat_nxt;
      stall_r <= stall_nxt;
    end
  end

  // Next-state, capture and record-push decisions; finish takes priority.
  always_comb begin
    state_nxt  = state_r;
    ts_nxt     = ts_r;
    lat_nxt    = lat_r;
    stall_nxt  = stall_r;
    push_s     = 1'b0;
    push_rec_s = {REC_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (finish) begin
          state_nxt = ST_FINISHED;
        end else if (accept_s) begin
          ts_nxt    = cycle_cnt_r;
          lat_nxt   = {LAT_W{1'b0}};
          stall_nxt = {LAT_W{1'b0}};
          if (mon_done && mon_continue) begin
            push_s     = 1'b1;
            push_rec_s = {1'b0, {LAT_W{1'b0}}, {LAT_W{1'b0}}, cycle_cnt_r};
          end else if (mon_done) begin
            // This done cycle already counts as one stalled cycle.
            state_nxt = ST_WAIT_CONT;
            stall_nxt = LAT_W'(1);
          end else begin
            state_nxt = ST_BUSY;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        lat_nxt = lat_inc_s;
        if (finish) begin
          push_s     = 1'b1;
          push_rec_s = {1'b1, stall_r, lat_inc_s, ts_r};
          state_nxt  = ST_FINISHED;
        end else if (mon_done && mon_continue) begin
          push_s     = 1'b1;
          push_rec_s = {1'b0, stall_r, lat_inc_s, ts_r};
          if (accept_s) begin
            // Back-to-back transaction: restart capture without leaving BUSY.
            ts_nxt    = cycle_cnt_r;
            lat_nxt   = {LAT_W{1'b0}};
            stall_nxt = {LAT_W{1'b0}};
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (mon_done) begin
          state_nxt = ST_WAIT_CONT;
          stall_nxt = LAT_W'(1);
        end else begin
          state_nxt = ST_BUSY;
        end
      end
      ST_WAIT_CONT: begin
        if (finish) begin
          push_s     = 1'b1;
          push_rec_s = {1'b1, (mon_continue ? stall_r : stall_inc_s), lat_r, ts_r};
          state_nxt  = ST_FINISHED;
        end else if (mon_continue) begin
          push_s     = 1'b1;
          push_rec_s = {1'b0, stall_r, lat_r, ts_r};
          state_nxt  = ST_IDLE;
        end else begin
          stall_nxt = stall_inc_s;
        end
      end
      ST_FINISHED: begin
        state_nxt = ST_FINISHED;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Drop accounting for records that find the FIFO full.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_cnt_r <= {LAT_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc(drop_cnt_r);
      overflow_r <= 1'b1;
    end
  end

  ap_txn_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (push_s),
    .push_data (push_rec_s),
    .pop       (rec_ready),
    .full      (full_s),
    .empty     (empty_s),
    .head      (rec_data)
  );

  assign rec_valid = ~empty_s;
  assign drop_cnt  = drop_cnt_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_ap_txn_recorder.sv
// tb_ap_txn_recorder
// Directed bench for ap_txn_recorder. Cycle numbers are counted from the
// release of ap_rst_n and match the DUT timestamp (cycle N = N edges after
// release). Inputs change on the falling edge; outputs are sampled there too.
module tb_ap_txn_recorder;
  import ap_txn_pkg::*;

  localparam int REC_W = TS_W_DEF + 2 * LAT_W_DEF + 1;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic                 mon_start = 1'b0;
  logic                 mon_ready = 1'b0;
  logic                 mon_done = 1'b0;
  logic                 mon_continue = 1'b1;
  logic                 finish = 1'b0;
  logic                 rec_valid;
  logic                 rec_ready = 1'b0;
  logic [REC_W-1:0]     rec_data;
  logic [LAT_W_DEF-1:0] drop_cnt;
  logic                 overflow;

  int nvec = 0;
  int nmis = 0;
  int cyc;

  logic [15:0] e_lat [9];
  logic [31:0] e_ts  [9];

  ap_txn_recorder dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .mon_start    (mon_start),
    .mon_ready    (mon_ready),
    .mon_done     (mon_done),
    .mon_continue (mon_continue),
    .finish       (finish),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .drop_cnt     (drop_cnt),
    .overflow     (overflow)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk(input logic inc, input logic [15:0] stall,
                                          input logic [15:0] lat, input logic [31:0] ts);
    return {inc, stall, lat, ts};
  endfunction

  task automatic go_to(input int n);
    while (cyc < n) @(negedge ap_clk);
  endtask

  task automatic do_reset();
    mon_start = 1'b0; mon_ready = 1'b0; mon_done = 1'b0;
    mon_continue = 1'b1; finish = 1'b0; rec_ready = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_data", rec_data, '0);
    chk("rst_drop", drop_cnt, '0);
    chk("rst_ovf", overflow, 1'b0);
    ap_rst_n = 1'b1;
  endtask

  task automatic accept_at(input int n);
    go_to(n);
    mon_start = 1'b1; mon_ready = 1'b1;
    @(negedge ap_clk);
    mon_start = 1'b0; mon_ready = 1'b0;
  endtask

  task automatic done_at(input int n);
    go_to(n);
    mon_done = 1'b1; mon_continue = 1'b1;
    @(negedge ap_clk);
    mon_done = 1'b0;
  endtask

  initial begin
    // Basic transaction: accept 10, done 15, record visible at 16.
    do_reset();
    accept_at(10);
    go_to(15);
    chk("a_valid_before", rec_valid, 1'b0);
    done_at(15);
    chk("a_valid_16", rec_valid, 1'b1);
    chk("a_rec", rec_data, mk(1'b0, 16'd0, 16'd5, 32'd10));
    @(negedge ap_clk);
    chk("a_hold", rec_data, mk(1'b0, 16'd0, 16'd5, 32'd10));
    rec_ready = 1'b1;
    @(negedge ap_clk);
    rec_ready = 1'b0;
    chk("a_popped", rec_valid, 1'b0);

    // Continue held low 20..22, released at 23.
    do_reset();
    accept_at(12);
    go_to(20);
    mon_done = 1'b1; mon_continue = 1'b0;
    @(negedge ap_clk);
    mon_done = 1'b0;
    go_to(23);
    chk("b_valid_23", rec_valid, 1'b0);
    mon_continue = 1'b1;
    @(negedge ap_clk);
    chk("b_valid_24", rec_valid, 1'b1);
    chk("b_rec", rec_data, mk(1'b0, 16'd3, 16'd8, 32'd12));

    // Done and new accept together at 30.
    do_reset();
    accept_at(25);
    go_to(30);
    mon_done = 1'b1; mon_start = 1'b1; mon_ready = 1'b1;
    @(negedge ap_clk);
    mon_done = 1'b0; mon_start = 1'b0; mon_ready = 1'b0;
    done_at(34);
    chk("c_rec1", rec_data, mk(1'b0, 16'd0, 16'd5, 32'd25));
    rec_ready = 1'b1;
    @(negedge ap_clk);
    rec_ready = 1'b0;
    chk("c_rec2", rec_data, mk(1'b0, 16'd0, 16'd4, 32'd30));

    // Finish while BUSY; later traffic is ignored.
    do_reset();
    accept_at(35);
    go_to(40);
    finish = 1'b1;
    @(negedge ap_clk);
    finish = 1'b0;
    chk("d_valid", rec_valid, 1'b1);
    chk("d_rec", rec_data, mk(1'b1, 16'd0, 16'd5, 32'd35));
    rec_ready = 1'b1;
    @(negedge ap_clk);
    rec_ready = 1'b0;
    accept_at(43);
    done_at(45);
    go_to(48);
    chk("d_no_more", rec_valid, 1'b0);

    // Nine transactions into an 8-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      e_ts[i]  = 32'(5 + 6 * i);
      e_lat[i] = 16'(1 + (i % 3));
      accept_at(5 + 6 * i);
      done_at(5 + 6 * i + 1 + (i % 3));
    end
    go_to(60);
    chk("e_drop", drop_cnt, 16'd1);
    chk("e_ovf", overflow, 1'b1);
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("e_drain_valid", rec_valid, 1'b1);
      chk("e_drain_rec", rec_data, mk(1'b0, 16'd0, e_lat[i], e_ts[i]));
      @(negedge ap_clk);
    end
    chk("e_empty", rec_valid, 1'b0);
    chk("e_ovf_sticky", overflow, 1'b1);
    rec_ready = 1'b0;

    // Saturating latency, then reset in the middle of a transaction.
    do_reset();
    accept_at(5);
    done_at(70005);
    go_to(70008);
    chk("f_sat_rec", rec_data, mk(1'b0, 16'd0, 16'hFFFF, 32'd5));
    accept_at(70010);
    go_to(70015);
    ap_rst_n = 1'b0;
    #1;
    chk("f_rst_valid", rec_valid, 1'b0);
    chk("f_rst_data", rec_data, '0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    done_at(3);
    go_to(20);
    chk("f_no_rec", rec_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ap_txn_recorder.md
AP_TXN_RECORDER -- requirements
Module: ap_txn_recorder

Interface
REQ-001 Parameter FIFO_DEPTH, 8, record FIFO entries (power of two, >=2).
REQ-002 Parameter TS_W, 32, timestamp width.
REQ-003 Parameter LAT_W, 16, latency and stall counter width.
REQ-004 ap_clk  input  1  single clock; all logic rising-edge.
REQ-005 ap_rst_n  input  1  asynchronous, active-low reset.
REQ-006 mon_start  input  1  observed ap_start of the monitored HLS module.
REQ-007 mon_ready  input  1  observed ap_ready.
REQ-008 mon_done  input  1  observed ap_done.
REQ-009 mon_continue  input  1  observed ap_continue (tie 1 for non-dataflow modules).
REQ-010 finish  input  1  simulation/run finish indication.
REQ-011 rec_valid  output  1  record available at FIFO head.
REQ-012 rec_ready  input  1  consumer accepts head record.
REQ-013 rec_data  output  TS_W+2*LAT_W+1  {incomplete, stall, latency, start_ts}, MSB first.
REQ-014 drop_cnt  output  LAT_W  records lost to a full FIFO, saturating.
REQ-015 overflow  output  1  sticky; set on first dropped record.

Function
REQ-016 Free-running cycle_cnt (TS_W) shall increment every cycle from 0 after reset and wrap at 2^TS_W.
REQ-017 Accept event shall be mon_start & mon_ready in one cycle; done event shall be mon_done.
REQ-018 FSM states shall be IDLE, BUSY, WAIT_CONT, FINISHED.
REQ-019 IDLE: accept -> capture start_ts=cycle_cnt, latency=0, stall=0, go BUSY; accept with done in same cycle -> record latency 0 (push if mon_continue, else WAIT_CONT).
REQ-020 BUSY: latency shall increment each cycle, saturating at 2^LAT_W-1; done & mon_continue -> push record, go IDLE; done & !mon_continue -> go WAIT_CONT.
REQ-021 Latency shall equal done cycle minus accept cycle (saturated).
REQ-022 WAIT_CONT: stall shall increment each cycle mon_continue is low (saturating); mon_continue high -> push record, go IDLE.
REQ-023 Done with simultaneous new accept (BUSY) shall push the finished record and restart capture with start_ts=current cycle_cnt, staying BUSY.
REQ-024 finish in BUSY or WAIT_CONT shall push the current record with incomplete=1 and go FINISHED; finish in IDLE shall go FINISHED without a record.
REQ-025 FINISHED shall ignore all mon_* inputs until reset; FIFO draining shall continue.
REQ-026 FIFO shall be first-word fall-through: rec_valid high exactly when non-empty, rec_data = head; pop on rec_valid & rec_ready.
REQ-027 A pushed record shall appear at rec_valid the cycle after the push event when FIFO was empty.
REQ-028 Push when full without simultaneous pop shall drop the record, increment drop_cnt (saturating), set overflow.
REQ-029 Push and pop in the same cycle when full shall accept the push, occupancy unchanged.
REQ-030 rec_data shall not change while rec_valid & !rec_ready.

Reset
REQ-031 ap_rst_n low shall immediately force: state IDLE, cycle_cnt 0, FIFO empty, rec_valid 0, rec_data 0, drop_cnt 0, overflow 0.
REQ-032 Reset mid-transaction shall discard the in-flight record without pushing it.

Structure
REQ-033 Package ap_txn_pkg shall hold the FSM state enum, record struct type and default parameter constants.
REQ-034 FIFO shall be a separate sub-module ap_txn_rec_fifo (depth/width parameterized, full/empty, FWFT).

Verification
REQ-035 Accept at cycle 10, done at 15, continue=1 -> one record {ts=10, lat=5, stall=0, inc=0}, rec_valid high cycle 16.
REQ-036 Done at cycle 20 with continue low cycles 20-22, high at 23 -> stall=3, record pushed at 23.
REQ-037 rec_ready=0, 9 complete transactions -> 8 records held, drop_cnt=1, overflow=1; draining returns records in order.
REQ-038 Done and new accept both at cycle 30 -> first record pushed, second record start_ts=30.
REQ-039 finish at cycle 40 while BUSY (accepted 35) -> record {ts=35, lat=5, inc=1}; later accepts produce no records.
REQ-040 Transaction of 70000 cycles -> latency 0xFFFF; ap_rst_n low mid-BUSY -> rec_valid 0 same cycle, no record.
